// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: single-command DMA copy sequencer issuing tagged 64-bit reads/writes through a slot table
package dma_pkg;
  localparam int DMA_ADDR_W = 40;
  typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_e;
  typedef struct packed {
    req_type_e             req_type;
    logic [6:0]            tid;
    logic [DMA_ADDR_W-1:0] addr;
    logic [63:0]           wdata;
    logic [7:0]            mask;
  } dma_req_t;
  typedef struct packed {
    logic [6:0]  tid;
    logic [63:0] rdata;
    logic        is_wr_rsp;
  } dma_rsp_t;
endpackage

module dma_copy_ctrl
  import dma_pkg::*;
#(
  parameter int N_SLOT = 8,
  parameter int ADDR_W = 40,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_beats,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              req_valid,
  output dma_req_t          req,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  dma_rsp_t          rsp,
  output logic              rsp_ready
);
  localparam int SW = $clog2(N_SLOT);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {FREE, RD_PEND, DATA} slot_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  beats_q, beats_d, rd_iss_q, rd_iss_d, wr_iss_q, wr_iss_d, wr_ack_q, wr_ack_d;
  logic              err_q, err_d, hold_q, hold_d;
  dma_req_t          hreq_q, hreq_d, arb_req;
  slot_e             st_q [N_SLOT];
  slot_e             st_d [N_SLOT];
  logic [LEN_W-1:0]  idx_q [N_SLOT];
  logic [LEN_W-1:0]  idx_d [N_SLOT];
  logic [63:0]       data_q [N_SLOT];
  logic [63:0]       data_d [N_SLOT];
  logic              any_free, any_data, all_free, rd_ok, wr_ok, acc, in_rng;
  logic [SW-1:0]     free_s, data_s, acc_s, rsp_s;

  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = err_q;
  assign rsp_ready = 1'b1;
  assign req_valid = hold_q | wr_ok | rd_ok;
  assign req       = hold_q ? hreq_q : (wr_ok | rd_ok) ? arb_req : '0;

  // pick lowest-index DATA slot for a write, else lowest-index FREE slot for a read
  always_comb begin
    any_free = 1'b0;
    any_data = 1'b0;
    all_free = 1'b1;
    free_s   = '0;
    data_s   = '0;
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        any_free = 1'b1;
        free_s   = SW'(i);
      end
      if (st_q[i] == DATA) begin
        any_data = 1'b1;
        data_s   = SW'(i);
      end
      if (st_q[i] != FREE) all_free = 1'b0;
    end
    wr_ok            = state_q == RUN && any_data;
    rd_ok            = state_q == RUN && any_free && rd_iss_q < beats_q;
    arb_req.req_type = wr_ok ? REQ_WRITE : REQ_READ;
    arb_req.tid      = wr_ok ? {1'b1, 6'(data_s)} : {1'b0, 6'(free_s)};
    arb_req.addr     = wr_ok ? dst_q + (ADDR_W'(idx_q[data_s]) << 3) : src_q + (ADDR_W'(rd_iss_q) << 3);
    arb_req.wdata    = wr_ok ? data_q[data_s] : 64'd0;
    arb_req.mask     = wr_ok ? 8'hFF : 8'h00;
  end

  // next state: request hold, accepts, responses, command and FSM transitions
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    beats_d  = beats_q;
    rd_iss_d = rd_iss_q;
    wr_iss_d = wr_iss_q;
    wr_ack_d = wr_ack_q;
    err_d    = err_q;
    st_d     = st_q;
    idx_d    = idx_q;
    data_d   = data_q;
    acc      = req_valid & req_ready;
    hold_d   = req_valid & ~req_ready;
    hreq_d   = req;
    acc_s    = req.tid[SW-1:0];
    rsp_s    = rsp.tid[SW-1:0];
    in_rng   = {1'b0, rsp.tid[5:0]} < 7'(N_SLOT);
    if (acc && req.req_type == REQ_WRITE) begin
      st_d[acc_s] = FREE;
      wr_iss_d    = wr_iss_q + LEN_W'(1);
    end
    if (acc && req.req_type == REQ_READ) begin
      st_d[acc_s]  = RD_PEND;
      idx_d[acc_s] = rd_iss_q;
      rd_iss_d     = rd_iss_q + LEN_W'(1);
    end
    if (rsp_valid) begin
      if (!rsp.is_wr_rsp && !rsp.tid[6] && in_rng && st_q[rsp_s] == RD_PEND) begin
        st_d[rsp_s]   = DATA;
        data_d[rsp_s] = rsp.rdata;
      end else if (rsp.is_wr_rsp && rsp.tid[6] && in_rng && state_q == RUN && wr_ack_q < wr_iss_q) begin
        wr_ack_d = wr_ack_q + LEN_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
    if (state_q == IDLE && cmd_valid) begin
      src_d    = cmd_src;
      dst_d    = cmd_dst;
      beats_d  = cmd_beats;
      rd_iss_d = '0;
      wr_iss_d = '0;
      wr_ack_d = '0;
      err_d    = 1'b0;
      state_d  = cmd_beats == '0 ? DONE : RUN;
    end
    if (state_q == RUN && rd_iss_q == beats_q && wr_iss_q == beats_q && wr_ack_q == beats_q && all_free)
      state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end

  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      beats_q  <= '0;
      rd_iss_q <= '0;
      wr_iss_q <= '0;
      wr_ack_q <= '0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
      hreq_q   <= '0;
      for (int i = 0; i < N_SLOT; i++) begin
        st_q[i]   <= FREE;
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      beats_q  <= beats_d;
      rd_iss_q <= rd_iss_d;
      wr_iss_q <= wr_iss_d;
      wr_ack_q <= wr_ack_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      hreq_q   <= hreq_d;
      st_q     <= st_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end
endmodule

// File: tb/tb_dma_copy_ctrl.sv
// tb_dma_copy_ctrl: directed scenario bench for dma_copy_ctrl
module tb_dma_copy_ctrl;
  import dma_pkg::*;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [39:0] cmd_src = '0, cmd_dst = '0;
  logic [15:0] cmd_beats = '0;
  logic        cmd_ready, busy, done, err, req_valid, rsp_ready;
  logic        req_ready = 1'b0, rsp_valid = 1'b0;
  dma_req_t    req;
  dma_rsp_t    rsp = '0;
  int          errors = 0, checks = 0;
  int          wr_n, rd_n, done_n;
  logic [39:0] wr_addr [64];
  logic [63:0] wr_data [64];
  logic [6:0]  wr_tid [64];
  logic [7:0]  wr_mask [64];
  logic [39:0] rd_addr [64];
  logic [6:0]  rd_tid [64];
  logic [6:0]  rdq_tid [$];
  logic [63:0] rdq_data [$];
  logic [6:0]  wrq_tid [$];

  always #5 clk = ~clk;

  dma_copy_ctrl dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_beats(cmd_beats), .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err),
    .req_valid(req_valid), .req(req), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp(rsp), .rsp_ready(rsp_ready)
  );

  function automatic logic [63:0] dat(input logic [39:0] a);
    return 64'hDA7A_0000_0000_0000 ^ {24'h0, a};
  endfunction

  task automatic start(input logic [39:0] s, input logic [39:0] d, input logic [15:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_beats = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // memory-side responder: answers each accepted request one cycle later and records traffic
  task automatic serve(input int max_cyc, input int stop_wr);
    wr_n = 0;
    rd_n = 0;
    done_n = 0;
    for (int n = 0; n < max_cyc; n++) begin
      if (done) begin
        done_n++;
        rsp_valid = 1'b0;
        break;
      end
      if (rdq_tid.size() > 0) begin
        rsp_valid = 1'b1;
        rsp.tid = rdq_tid.pop_front();
        rsp.rdata = rdq_data.pop_front();
        rsp.is_wr_rsp = 1'b0;
      end else if (wrq_tid.size() > 0) begin
        rsp_valid = 1'b1;
        rsp.tid = wrq_tid.pop_front();
        rsp.rdata = '0;
        rsp.is_wr_rsp = 1'b1;
      end else rsp_valid = 1'b0;
      if (req_valid && req_ready) begin
        if (req.req_type == REQ_READ) begin
          if (rd_n < 64) begin
            rd_addr[rd_n] = req.addr;
            rd_tid[rd_n] = req.tid;
          end
          rd_n++;
          rdq_tid.push_back(req.tid);
          rdq_data.push_back(dat(req.addr));
        end else begin
          if (wr_n < 64) begin
            wr_addr[wr_n] = req.addr;
            wr_data[wr_n] = req.wdata;
            wr_tid[wr_n] = req.tid;
            wr_mask[wr_n] = req.mask;
          end
          wr_n++;
          wrq_tid.push_back(req.tid);
        end
      end
      if (wr_n == stop_wr) break;
      @(negedge clk);
    end
  endtask

  task automatic clear_q();
    rdq_tid.delete();
    rdq_data.delete();
    wrq_tid.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cmd_ready, busy, done, err, req_valid} !== 5'b10000)
      begin errors++; $display("FAIL reset_outs got=%b want=10000", {cmd_ready, busy, done, err, req_valid}); end
    checks++;
    if (req !== '0 || rsp_ready !== 1'b1)
      begin errors++; $display("FAIL reset_req got req=%h rsp_ready=%b want 0/1", req, rsp_ready); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    req_ready = 1'b1;
    clear_q();
    start(40'h1000, 40'h2000, 16'd1);
    serve(100, -1);
    checks++;
    if (rd_n !== 1 || rd_addr[0] !== 40'h1000 || rd_tid[0] !== 7'h00)
      begin errors++; $display("FAIL single_read got n=%0d addr=%h tid=%h want 1/1000/00", rd_n, rd_addr[0], rd_tid[0]); end
    checks++;
    if (wr_n !== 1 || wr_addr[0] !== 40'h2000 || wr_tid[0] !== 7'h40 || wr_mask[0] !== 8'hFF)
      begin errors++; $display("FAIL single_write got n=%0d addr=%h tid=%h mask=%h want 1/2000/40/ff", wr_n, wr_addr[0], wr_tid[0], wr_mask[0]); end
    checks++;
    if (wr_data[0] !== dat(40'h1000))
      begin errors++; $display("FAIL single_data got=%h want=%h", wr_data[0], dat(40'h1000)); end
    checks++;
    if (done_n !== 1 || busy !== 1'b1)
      begin errors++; $display("FAIL single_done got done_n=%0d busy=%b want 1/1", done_n, busy); end
    @(negedge clk);
    checks++;
    if ({done, busy, cmd_ready, err} !== 4'b0010)
      begin errors++; $display("FAIL single_after got=%b want=0010", {done, busy, cmd_ready, err}); end
  endtask

  task automatic test_zero();
    start(40'h1000, 40'h2000, 16'd0);
    checks++;
    if ({done, busy, req_valid, cmd_ready} !== 4'b1100)
      begin errors++; $display("FAIL zero_done got=%b want=1100", {done, busy, req_valid, cmd_ready}); end
    @(negedge clk);
    checks++;
    if ({done, busy, req_valid, cmd_ready} !== 4'b0001)
      begin errors++; $display("FAIL zero_idle got=%b want=0001", {done, busy, req_valid, cmd_ready}); end
  endtask

  task automatic test_window();
    logic [19:0] seen;
    logic ok;
    int b;
    clear_q();
    rd_n = 0;
    start(40'h1000, 40'h2000, 16'd20);
    for (int n = 0; n < 12; n++) begin
      if (req_valid && req_ready) begin
        if (rd_n < 64) begin
          rd_addr[rd_n] = req.addr;
          rd_tid[rd_n] = req.tid;
        end
        rd_n++;
      end
      @(negedge clk);
    end
    checks++;
    if (rd_n !== 8 || req_valid !== 1'b0)
      begin errors++; $display("FAIL window_stall got reads=%0d req_valid=%b want 8/0", rd_n, req_valid); end
    ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (rd_tid[i] !== 7'(i) || rd_addr[i] !== 40'h1000 + 40'(8 * i)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL window_reads got tid0=%h tid7=%h addr7=%h want 00/07/1038", rd_tid[0], rd_tid[7], rd_addr[7]); end
    req_ready = 1'b0;
    for (int s = 7; s >= 0; s--) begin
      rsp_valid = 1'b1;
      rsp.tid = 7'(s);
      rsp.rdata = dat(40'h1000 + 40'(8 * s));
      rsp.is_wr_rsp = 1'b0;
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    req_ready = 1'b1;
    serve(600, -1);
    ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (wr_tid[i] !== (i == 0 ? 7'h47 : 7'(7'h40 + i - 1))) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL window_order got %h %h %h want 47 40 41", wr_tid[0], wr_tid[1], wr_tid[2]); end
    seen = '0;
    ok = 1'b1;
    for (int i = 0; i < wr_n && i < 64; i++) begin
      b = int'((wr_addr[i] - 40'h2000) >> 3);
      if (b < 0 || b >= 20 || wr_addr[i][2:0] != 3'b0 || wr_mask[i] !== 8'hFF) ok = 1'b0;
      else if (seen[b] || wr_data[i] !== dat(40'h1000 + 40'(8 * b))) ok = 1'b0;
      else seen[b] = 1'b1;
    end
    checks++;
    if (!ok || seen !== 20'hFFFFF || wr_n !== 20)
      begin errors++; $display("FAIL window_writes got n=%0d seen=%h ok=%b want 20/fffff/1", wr_n, seen, ok); end
    checks++;
    if (done_n !== 1 || err !== 1'b0)
      begin errors++; $display("FAIL window_done got done_n=%0d err=%b want 1/0", done_n, err); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    clear_q();
    req_ready = 1'b1;
    start(40'h3000, 40'h4000, 16'd2);
    checks++;
    if (!req_valid || req.req_type !== REQ_READ || req.tid !== 7'h00 || req.addr !== 40'h3000)
      begin errors++; $display("FAIL hold_rd0 got v=%b tid=%h addr=%h want 1/00/3000", req_valid, req.tid, req.addr); end
    @(negedge clk);
    req_ready = 1'b0;
    checks++;
    if (!req_valid || req.tid !== 7'h01 || req.addr !== 40'h3008)
      begin errors++; $display("FAIL hold_rd1 got v=%b tid=%h addr=%h want 1/01/3008", req_valid, req.tid, req.addr); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!req_valid || req.req_type !== REQ_READ || req.tid !== 7'h01 || req.addr !== 40'h3008 || req.mask !== 8'h00)
        begin errors++; $display("FAIL hold_stable cyc=%0d got v=%b tid=%h addr=%h want 1/01/3008", i, req_valid, req.tid, req.addr); end
      rsp_valid = i == 0;
      rsp.tid = 7'h00;
      rsp.rdata = dat(40'h3000);
      rsp.is_wr_rsp = 1'b0;
    end
    req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (!req_valid || req.req_type !== REQ_WRITE || req.tid !== 7'h40 || req.addr !== 40'h4000 || req.wdata !== dat(40'h3000))
      begin errors++; $display("FAIL hold_wrprio got v=%b tid=%h addr=%h data=%h want 1/40/4000", req_valid, req.tid, req.addr, req.wdata); end
    rsp_valid = 1'b1;
    rsp.tid = 7'h01;
    rsp.rdata = dat(40'h3008);
    rsp.is_wr_rsp = 1'b0;
    wrq_tid.push_back(7'h40);
    @(negedge clk);
    serve(100, -1);
    checks++;
    if (done_n !== 1 || wr_n !== 1 || wr_addr[0] !== 40'h4008 || wr_data[0] !== dat(40'h3008) || err !== 1'b0)
      begin errors++; $display("FAIL hold_finish got done_n=%0d wr_n=%0d addr=%h err=%b want 1/1/4008/0", done_n, wr_n, wr_addr[0], err); end
    @(negedge clk);
  endtask

  task automatic test_err();
    clear_q();
    rsp_valid = 1'b1;
    rsp.tid = 7'h05;
    rsp.rdata = 64'h1234;
    rsp.is_wr_rsp = 1'b0;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || req_valid !== 1'b0)
      begin errors++; $display("FAIL err_set got err=%b req_valid=%b want 1/0", err, req_valid); end
    start(40'h5000, 40'h6000, 16'd1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", err); end
    serve(100, -1);
    checks++;
    if (done_n !== 1 || wr_n !== 1 || wr_addr[0] !== 40'h6000 || wr_data[0] !== dat(40'h5000))
      begin errors++; $display("FAIL err_copy got done_n=%0d wr_n=%0d addr=%h data=%h want 1/1/6000", done_n, wr_n, wr_addr[0], wr_data[0]); end
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp.tid = 7'h03;
    rsp.is_wr_rsp = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_mismatch got=%b want=1", err); end
  endtask

  task automatic test_midreset();
    clear_q();
    start(40'h7000, 40'h8000, 16'd10);
    serve(200, 3);
    checks++;
    if (wr_n !== 3 || busy !== 1'b1) begin errors++; $display("FAIL mid_progress got wr_n=%0d busy=%b want 3/1", wr_n, busy); end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, req_valid} !== 5'b10000 || req !== '0)
      begin errors++; $display("FAIL mid_async got=%b req=%h want 10000/0", {cmd_ready, busy, done, err, req_valid}, req); end
    rsp_valid = 1'b0;
    clear_q();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp.tid = 7'h02;
    rsp.rdata = 64'hBAD;
    rsp.is_wr_rsp = 1'b0;
    @(negedge clk);
    rsp_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL mid_stale got=%b want=1", err); end
    start(40'h9000, 40'hA000, 16'd3);
    serve(200, -1);
    checks++;
    if (done_n !== 1 || wr_n !== 3 || err !== 1'b0 || wr_addr[2] !== 40'hA010 || wr_data[2] !== dat(40'h9010))
      begin errors++; $display("FAIL mid_recover got done_n=%0d wr_n=%0d err=%b addr=%h want 1/3/0/a010", done_n, wr_n, err, wr_addr[2]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_window();
    test_hold();
    test_err();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
